// File: rtl/calc_sequencer.sv
// Sequencer for the shared calculator datapath: zero-fills the operand memory and
// walks A/B word pairs, emitting one result record per pair on a valid/ready stream.
module calc_sequencer #(
    parameter int NUM_WORDS = 512,
    parameter int AW        = 9,
    parameter int ALU_LAT   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [15:0]   mem_rdata,
    output logic          mem_we,
    output logic [15:0]   mem_wdata,
    output logic [15:0]   op_a,
    output logic [15:0]   op_b,
    input  logic [16:0]   res_sum,
    input  logic [15:0]   res_diff,
    input  logic [31:0]   res_prod,
    input  logic [15:0]   res_quo,
    input  logic [15:0]   res_rem,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-2:0] out_index,
    output logic [15:0]   out_a,
    output logic [15:0]   out_b,
    output logic [16:0]   out_sum,
    output logic [15:0]   out_diff,
    output logic [31:0]   out_prod,
    output logic [15:0]   out_quo,
    output logic [15:0]   out_rem,
    output logic          idle,
    output logic          cleared,
    output logic          done,
    output logic [1:0]    status,
    output logic [AW-1:0] pair_count
);

    localparam int WW = $clog2(ALU_LAT + 1);
    localparam logic [AW-2:0] K_LAST    = (AW-1)'(NUM_WORDS/2 - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_WORDS - 1);
    localparam logic [1:0] ST_END   = 2'd1;
    localparam logic [1:0] ST_ZEROB = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RD_A, S_RD_B, S_CHK, S_WAIT, S_EMIT, S_FIN
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg;
    logic [AW-2:0]   k_reg;
    logic [15:0]     a_reg;
    logic [WW-1:0]   wait_reg;
    logic            abort_pend_reg;
    logic            last_wait;
    logic            last_pair;

    assign last_wait = (wait_reg == WW'(1));
    assign last_pair = (k_reg == K_LAST);
    assign mem_wdata = 16'd0;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (clear)      state_next = S_CLEAR;
                else if (start) state_next = S_RD_A;
            end
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = addr_reg;
                if (addr_reg == ADDR_LAST) state_next = S_IDLE;
            end
            S_RD_A: begin
                mem_addr   = {k_reg, 1'b0};
                mem_rd_en  = 1'b1;
                state_next = abort ? S_FIN : S_RD_B;
            end
            S_RD_B: begin
                mem_addr   = {k_reg, 1'b1};
                mem_rd_en  = 1'b1;
                state_next = abort ? S_FIN : S_CHK;
            end
            S_CHK: begin
                // A zero divisor never reaches the operand registers.
                if (abort || mem_rdata == 16'd0) state_next = S_FIN;
                else                             state_next = S_WAIT;
            end
            S_WAIT: begin
                if (abort)          state_next = S_FIN;
                else if (last_wait) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (abort_pend_reg || abort || last_pair) state_next = S_FIN;
                    else                                      state_next = S_RD_A;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Strobes are suppressed while reset is asserted so a reset never writes memory.
        if (reset) begin
            mem_we    = 1'b0;
            mem_rd_en = 1'b0;
        end
    end

    assign idle      = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_EMIT) && !reset;
    assign done      = (state_reg == S_FIN) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg       <= '0;
            k_reg          <= '0;
            a_reg          <= '0;
            wait_reg       <= '0;
            abort_pend_reg <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            out_index      <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_sum        <= '0;
            out_diff       <= '0;
            out_prod       <= '0;
            out_quo        <= '0;
            out_rem        <= '0;
            cleared        <= 1'b0;
            status         <= 2'd0;
            pair_count     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (clear) begin
                        addr_reg <= '0;
                    end else if (start) begin
                        k_reg          <= '0;
                        pair_count     <= '0;
                        status         <= 2'd0;
                        abort_pend_reg <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    addr_reg <= addr_reg + AW'(1);
                    if (addr_reg == ADDR_LAST) cleared <= 1'b1;
                end
                S_RD_A: begin
                    if (abort) status <= ST_ABORT;
                end
                S_RD_B: begin
                    a_reg <= mem_rdata;
                    if (abort) status <= ST_ABORT;
                end
                S_CHK: begin
                    if (abort) begin
                        status <= ST_ABORT;
                    end else if (mem_rdata == 16'd0) begin
                        status <= ST_ZEROB;
                    end else begin
                        op_a     <= a_reg;
                        op_b     <= mem_rdata;
                        wait_reg <= WW'(ALU_LAT);
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        status <= ST_ABORT;
                    end else begin
                        wait_reg <= wait_reg - WW'(1);
                        if (last_wait) begin
                            out_index <= k_reg;
                            out_a     <= op_a;
                            out_b     <= op_b;
                            out_sum   <= res_sum;
                            out_diff  <= res_diff;
                            out_prod  <= res_prod;
                            out_quo   <= res_quo;
                            out_rem   <= res_rem;
                        end
                    end
                end
                S_EMIT: begin
                    // An abort during EMIT still lets the current record complete.
                    if (abort) abort_pend_reg <= 1'b1;
                    if (out_ready) begin
                        pair_count <= pair_count + AW'(1);
                        if (abort_pend_reg || abort) status <= ST_ABORT;
                        else if (last_pair)          status <= ST_END;
                        else                         k_reg  <= k_reg + (AW-1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: memory and datapath models, table-driven
// record checks plus directed clear, backpressure, abort and reset sequences.
module tb_calc_sequencer;

    localparam int NUM_WORDS = 512;
    localparam int AW        = 9;
    localparam int ALU_LAT   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [15:0]   mem_rdata = 16'd0;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   op_a, op_b;
    logic [16:0]   res_sum;
    logic [15:0]   res_diff;
    logic [31:0]   res_prod;
    logic [15:0]   res_quo, res_rem;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-2:0] out_index;
    logic [15:0]   out_a, out_b;
    logic [16:0]   out_sum;
    logic [15:0]   out_diff;
    logic [31:0]   out_prod;
    logic [15:0]   out_quo, out_rem;
    logic          idle, cleared, done;
    logic [1:0]    status;
    logic [AW-1:0] pair_count;

    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [15:0]   tb_wdata = '0;
    logic [15:0]   mem [NUM_WORDS];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
        logic [15:0] diff;
        logic [31:0] prod;
        logic [15:0] quo;
        logic [15:0] rem;
        int          hold;
    } vec_t;
    vec_t vecs [3];

    calc_sequencer #(.NUM_WORDS(NUM_WORDS), .AW(AW), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .op_a(op_a), .op_b(op_b),
        .res_sum(res_sum), .res_diff(res_diff), .res_prod(res_prod),
        .res_quo(res_quo), .res_rem(res_rem), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_a(out_a), .out_b(out_b),
        .out_sum(out_sum), .out_diff(out_diff), .out_prod(out_prod),
        .out_quo(out_quo), .out_rem(out_rem), .idle(idle), .cleared(cleared),
        .done(done), .status(status), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr]  <= tb_wdata;
        if (mem_rd_en)  mem_rdata     <= mem[mem_addr];
    end

    always_comb begin
        res_sum  = {1'b0, op_a} + {1'b0, op_b};
        res_diff = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        res_prod = {16'd0, op_a} * {16'd0, op_b};
        res_quo  = (op_b != 16'd0) ? (op_a / op_b) : 16'hFFFF;
        res_rem  = (op_b != 16'd0) ? (op_a % op_b) : 16'hFFFF;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (out_valid && out_ready) begin
            hs_cnt = hs_cnt + 1;
            $display("rec k=%0d a=%h b=%h sum=%h diff=%h prod=%h quo=%h rem=%h",
                     out_index, out_a, out_b, out_sum, out_diff, out_prod, out_quo, out_rem);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: out_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == base) begin
            checks++;
            failures++;
            $display("FAIL %s: done timeout got none expected pulse", name);
        end
    endtask

    task automatic write_word(input int addr, input logic [15:0] data);
        tb_we    = 1'b1;
        tb_addr  = AW'(addr);
        tb_wdata = data;
        tick();
        tb_we    = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 3; i++) begin
            write_word(2*i, vecs[i].a);
            write_word(2*i + 1, vecs[i].b);
        end
        write_word(6, 16'd5);
        write_word(7, 16'd0);
    endtask

    initial begin
        int base_d, base_h, n, bad, k, last;
        logic [136:0] snap;

        vecs[0] = '{a:16'd7,      b:16'd3,      sum:17'd10,      diff:16'd4,  prod:32'd21,
                    quo:16'd2,  rem:16'd1, hold:0};
        vecs[1] = '{a:16'd100,    b:16'd10,     sum:17'd110,     diff:16'd90, prod:32'd1000,
                    quo:16'd10, rem:16'd0, hold:6};
        vecs[2] = '{a:16'hFFFF,   b:16'hFFFF,   sum:17'h1FFFE,   diff:16'd0,  prod:32'hFFFE0001,
                    quo:16'd1,  rem:16'd0, hold:0};

        // Reset state
        repeat (3) tick();
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_pair_count", 64'(pair_count), 64'd0);
        chk("rst_cleared", 64'(cleared), 64'd0);
        chk("rst_ops", 64'({op_a, op_b}), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_strobes", 64'({mem_we, mem_rd_en, done}), 64'd0);
        reset = 1'b0;
        tick();

        // Dirty the memory so the fill is observable
        for (int i = 0; i < NUM_WORDS; i++) write_word(i, 16'hA5A5);

        // Clear with start in the same cycle: clear wins, start mid-fill ignored
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        n = 0;
        bad = 0;
        while (mem_we && n < 600) begin
            if (mem_addr !== AW'(n) || mem_wdata !== 16'd0) bad++;
            start = (n == 100);
            abort = (n == 200);
            n++;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        chk("clear_len", 64'(n), 64'd512);
        chk("clear_addr_seq", 64'(bad), 64'd0);
        chk("clear_cleared", 64'(cleared), 64'd1);
        chk("clear_idle", 64'(idle), 64'd1);
        repeat (3) tick();
        chk("clear_start_dropped", 64'({idle, mem_rd_en}), 64'b10);

        // Pass over an all-zero memory stops at pair 0 on B == 0
        base_d = done_cnt;
        base_h = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("zero_pass", base_d, 50);
        chk("zero_status", 64'(status), 64'd2);
        chk("zero_pair_count", 64'(pair_count), 64'd0);
        chk("zero_records", 64'(hs_cnt - base_h), 64'd0);

        // Table-driven records with backpressure on k1
        load_table();
        out_ready = 1'b0;
        base_d = done_cnt;
        base_h = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("first_latency", 64'(n), 64'd5);
        for (int i = 0; i < 3; i++) begin
            wait_valid("tbl_valid");
            chk("tbl_index", 64'(out_index), 64'(i));
            chk("tbl_a", 64'(out_a), 64'(vecs[i].a));
            chk("tbl_b", 64'(out_b), 64'(vecs[i].b));
            chk("tbl_sum", 64'(out_sum), 64'(vecs[i].sum));
            chk("tbl_diff", 64'(out_diff), 64'(vecs[i].diff));
            chk("tbl_prod", 64'(out_prod), 64'(vecs[i].prod));
            chk("tbl_quo", 64'(out_quo), 64'(vecs[i].quo));
            chk("tbl_rem", 64'(out_rem), 64'(vecs[i].rem));
            snap = {out_index, out_a, out_b, out_sum, out_diff, out_prod, out_quo, out_rem};
            bad = 0;
            for (int h = 0; h < vecs[i].hold; h++) begin
                tick();
                if (!out_valid || mem_rd_en ||
                    {out_index, out_a, out_b, out_sum, out_diff, out_prod, out_quo, out_rem} !== snap)
                    bad++;
            end
            chk("tbl_hold_stable", 64'(bad), 64'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("tbl_valid_drop", 64'(out_valid), 64'd0);
            chk("tbl_next_read", 64'({mem_rd_en, mem_addr}), 64'({1'b1, AW'(2*(i+1))}));
        end
        wait_done("tbl_done", base_d, 50);
        chk("tbl_status", 64'(status), 64'd2);
        chk("tbl_pair_count", 64'(pair_count), 64'd3);
        chk("tbl_records", 64'(hs_cnt - base_h), 64'd3);
        tick();
        chk("tbl_one_done", 64'(done_cnt - base_d), 64'd1);

        // abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle_abort_ignored", 64'({idle, status}), 64'({1'b1, 2'd2}));

        // Full pass: every B nonzero, ready held high
        for (int i = 0; i < NUM_WORDS/2; i++) begin
            write_word(2*i, 16'(3*i));
            write_word(2*i + 1, 16'(i + 1));
        end
        out_ready = 1'b1;
        base_d = done_cnt;
        base_h = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        last = 0;
        n = 0;
        while (done_cnt == base_d && n < 2000) begin
            if (out_valid) begin
                chk("full_index", 64'(out_index), 64'(k));
                chk("full_sum", 64'(out_sum), 64'(4*k + 1));
                chk("full_quo", 64'(out_quo), 64'((3*k) / (k + 1)));
                if (k > 0) chk("full_gap", 64'(cyc - last), 64'd5);
                last = cyc;
                k++;
            end
            tick();
            n++;
        end
        chk("full_no_timeout", 64'(done_cnt != base_d), 64'd1);
        chk("full_count", 64'(k), 64'd256);
        chk("full_status", 64'(status), 64'd1);
        chk("full_pair_count", 64'(pair_count), 64'd256);
        tick();
        chk("full_one_done", 64'(done_cnt - base_d), 64'd1);

        // Abort in WAIT of k1
        load_table();
        out_ready = 1'b1;
        base_d = done_cnt;
        base_h = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("ab1_k0");
        repeat (4) tick();
        chk("ab1_in_wait_opa", 64'(op_a), 64'd100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("ab1_done", base_d, 20);
        chk("ab1_records", 64'(hs_cnt - base_h), 64'd1);
        chk("ab1_status", 64'(status), 64'd3);
        chk("ab1_pair_count", 64'(pair_count), 64'd1);

        // Abort in EMIT of k1 with ready low
        out_ready = 1'b0;
        base_d = done_cnt;
        base_h = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("ab2_k0");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("ab2_k1");
        chk("ab2_index", 64'(out_index), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bad = 0;
        repeat (2) begin
            if (!out_valid || mem_rd_en) bad++;
            tick();
        end
        chk("ab2_held", 64'(bad), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ab2_fin", 64'({done, mem_rd_en, out_valid}), 64'b100);
        chk("ab2_status", 64'(status), 64'd3);
        chk("ab2_pair_count", 64'(pair_count), 64'd2);
        tick();
        chk("ab2_idle", 64'({idle, mem_rd_en}), 64'b10);
        chk("ab2_records", 64'(hs_cnt - base_h), 64'd2);

        // Reset during WAIT of k2, then a normal pass
        out_ready = 1'b1;
        base_d = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("rs_k0");
        tick();
        wait_valid("rs_k1");
        repeat (4) tick();
        chk("rs_in_wait_opa", 64'(op_a), 64'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_idle", 64'(idle), 64'd1);
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_status", 64'(status), 64'd0);
        chk("rs_pair_count", 64'(pair_count), 64'd0);
        repeat (2) tick();
        chk("rs_no_done", 64'(done_cnt - base_d), 64'd0);
        base_d = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("rs2_k0");
        chk("rs2_first", 64'({out_index, out_a}), 64'({8'd0, 16'd7}));
        wait_done("rs2_done", base_d, 50);
        chk("rs2_status", 64'(status), 64'd2);
        chk("rs2_pair_count", 64'(pair_count), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Clocked controller that sequences the shared calculator datapath (sum, product, absolute difference, divide) over the 512 x 16-bit operand memory.
- Clears the memory on request.
- Walks word pairs (A = mem[2k], B = mem[2k+1]) and drives the operands to the combinational units.
- Captures their results and emits one result record per pair on a valid/ready stream.
- Stops on B == 0, end of memory, or abort, then reports why.
- Replaces the unclocked loop-and-wait sequencing with a synthesizable FSM.

Parameters:
- NUM_WORDS, 512: memory depth in 16-bit words. Must be even and a power of two.
- AW, 9: memory address width, log2(NUM_WORDS).
- ALU_LAT, 1: cycles the operands are held before results are sampled. Must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  request memory zero-fill. Sampled only in IDLE.
- start  in  1  request a pass over memory. Sampled only in IDLE.
- abort  in  1  stop the current pass.
- mem_addr  out  AW  memory address.
- mem_rd_en  out  1  read strobe. Read data is valid on mem_rdata the following cycle.
- mem_rdata  in  16  memory read data.
- mem_we  out  1  write strobe.
- mem_wdata  out  16  write data (always 0).
- op_a, op_b  out  16  registered operands to the datapath.
- res_sum  in  17; res_diff  in  16; res_prod  in  32; res_quo  in  16; res_rem  in  16  datapath results.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the record.
- out_index  out  AW-1  pair index k.
- out_a, out_b  out  16; out_sum  out  17; out_diff  out  16; out_prod  out  32; out_quo  out  16; out_rem  out  16  record fields.
- idle  out  1  FSM in IDLE.
- cleared  out  1  a zero-fill has completed since reset.
- done  out  1  one-cycle pulse at the end of a pass.
- status  out  2  pass result: 0 none, 1 END, 2 ZERO_B, 3 ABORT.
- pair_count  out  AW  records handshaken in the current or last pass.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0 except idle = 1.
  - op_a, op_b and all out_* record fields = 0.
  - Reset mid-operation aborts immediately: no done pulse, no memory write, status = 0 on the next cycle.
- States: IDLE, CLEAR, RD_A, RD_B, CHK, WAIT, EMIT, FIN.
- IDLE:
  - clear has priority; start is dropped when both are high in the same cycle.
  - clear -> CLEAR with the address counter at 0.
  - start -> RD_A with k = 0, pair_count = 0, status = 0.
  - abort in IDLE is ignored.
- CLEAR:
  - mem_we = 1, mem_wdata = 0, mem_addr = counter; the counter increments each cycle.
  - After address NUM_WORDS-1 is written, set cleared = 1 and go to IDLE.
  - The fill is exactly NUM_WORDS consecutive write cycles. abort, clear and start are ignored during the fill.
- RD_A: mem_addr = 2k, mem_rd_en = 1.
- RD_B: mem_addr = 2k+1, mem_rd_en = 1; capture A = mem_rdata.
- CHK:
  - If mem_rdata == 0: status = ZERO_B, go to FIN. op_a/op_b are not updated.
  - Otherwise: load op_a = A and op_b = mem_rdata, load the wait counter with ALU_LAT, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the final WAIT cycle, latch res_* and k into the out_* fields, then go to EMIT.
- EMIT:
  - out_valid = 1. Fields stay stable and no memory access occurs until out_ready = 1.
  - On the handshake, increment pair_count.
  - If k == NUM_WORDS/2-1: status = END, go to FIN. Otherwise k++ and go to RD_A.
  - out_valid is deasserted on the cycle after the handshake.
- FIN: done = 1 for one cycle, then go to IDLE. status and pair_count hold until the next accepted start.
- abort:
  - Sampled in RD_A, RD_B, CHK or WAIT: status = ABORT, go to FIN next cycle, no record emitted.
  - Sampled in EMIT: latched as pending. The current record is still handshaken, then status = ABORT, go to FIN even if k was the last pair.
  - ZERO_B seen in CHK in the same cycle as abort: ABORT wins.
- Timing:
  - Throughput with out_ready held high: 4 + ALU_LAT cycles per pair.
  - Latency: start sampled at cycle t gives the first out_valid at t + 4 + ALU_LAT.
- Width rules:
  - out_sum is the 17-bit carry-preserving sum.
  - out_prod is the full 32-bit product.
  - out_diff is |A - B|.
  - The divider is never driven with op_b = 0 while a record is pending.
  - pair_count is AW bits so that a full count of NUM_WORDS/2 does not wrap.

Test Plan:
- Clear: reset, then clear pulse -> mem_we high for 512 consecutive cycles, addr 0..511, wdata 0; then cleared = 1, idle = 1.
- Preload pairs (7,3), (100,10), (FFFF,FFFF), (5,0), then start -> three records:
  - k0: a7 b3 sum10 diff4 prod21 q2 r1.
  - k1: sum110 diff90 prod1000 q10 r0.
  - k2: sum1FFFE diff0 prodFFFE0001 q1 r0.
  - Then a done pulse, status = 2, pair_count = 3.
  - First out_valid exactly 5 cycles after start with ALU_LAT = 1.
- Backpressure: out_ready low for 6 cycles during k1 -> out_valid and all fields stable, mem_rd_en low throughout, k2 read starts the cycle after the handshake.
- Full pass: all 256 B nonzero, out_ready = 1 -> 256 records with index 0..255, status = 1, pair_count = 256, one done pulse.
- Abort:
  - In WAIT of k1 -> only k0 emitted, status = 3.
  - In EMIT of k1 with out_ready low -> k1 still handshaken, no k2 read, status = 3.
- Reset during WAIT of k2 -> next cycle idle = 1, out_valid = 0, status = 0, pair_count = 0, no done pulse; a following start runs a normal pass from k = 0.
